// File: rtl/ddr_burst_splitter_if.sv
// Command, write, response and read bus between an AXI-style master
// and a DDR controller front end; used on both sides of the splitter.
interface ddr_burst_splitter_if #(
    parameter int AW = 27
);
    logic          arw_valid;
    logic          arw_ready;
    logic [AW-1:0] arw_addr;
    logic [7:0]    arw_len;
    logic          arw_write;
    logic [1:0]    arw_id;
    logic          wvalid;
    logic          wready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wlast;
    logic          bvalid;
    logic          bready;
    logic [1:0]    bid;
    logic          rvalid;
    logic          rlast;
    logic [31:0]   rdata;
    logic [1:0]    rid;

    modport master (
        output arw_valid, arw_addr, arw_len, arw_write, arw_id,
        output wvalid, wdata, wstrb, wlast, bready,
        input  arw_ready, wready, bvalid, bid,
        input  rvalid, rlast, rdata, rid
    );

    modport slave (
        input  arw_valid, arw_addr, arw_len, arw_write, arw_id,
        input  wvalid, wdata, wstrb, wlast, bready,
        output arw_ready, wready, bvalid, bid,
        output rvalid, rlast, rdata, rid
    );
endinterface

// File: rtl/ddr_burst_splitter.sv
// Splits upstream bursts into controller commands that stay inside one
// DRAM row and never exceed MAX_BEATS beats; one command in flight.
module ddr_burst_splitter #(
    parameter int ROW_BITS  = 13,
    parameter int COL_BITS  = 11,
    parameter int MAX_BEATS = 64
) (
    input logic clk,
    input logic reset,
    ddr_burst_splitter_if.slave  u,
    ddr_burst_splitter_if.master d
);
    localparam int AW        = ROW_BITS + COL_BITS + 3;
    localparam int ROW_BEATS = 2 ** (COL_BITS - 1);
    localparam logic [8:0] MAXB = 9'(MAX_BEATS);

    typedef enum logic [2:0] {
        IDLE, CMD, WDATA, DRESP, UBRESP, RDATA
    } state_t;

    state_t              state, state_nx;
    logic [AW-1:0]       addr, addr_nx;
    logic [1:0]          id, id_nx;
    logic                write, write_nx;
    logic [8:0]          rem, rem_nx;
    logic [7:0]          cnt, cnt_nx;
    logic [COL_BITS-2:0] word;
    logic [COL_BITS-1:0] to_row;
    logic [8:0]          chunk;
    logic                unused_ok;

    assign word   = addr[COL_BITS:2];
    assign to_row = COL_BITS'(ROW_BEATS) - {1'b0, word};

    always_comb begin
        chunk = rem;
        if (to_row < COL_BITS'(chunk)) chunk = to_row[8:0];
        if (MAXB < chunk) chunk = MAXB;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            id    <= '0;
            write <= 1'b0;
            rem   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            addr  <= addr_nx;
            id    <= id_nx;
            write <= write_nx;
            rem   <= rem_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        id_nx    = id;
        write_nx = write;
        rem_nx   = rem;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: if (u.arw_valid) begin
                addr_nx  = u.arw_addr;
                id_nx    = u.arw_id;
                write_nx = u.arw_write;
                rem_nx   = {1'b0, u.arw_len} + 9'd1;
                state_nx = CMD;
            end
            CMD: if (d.arw_ready) begin
                // Address wraps freely into the next row, bank or 0.
                addr_nx  = addr + AW'({chunk, 2'b00});
                rem_nx   = rem - chunk;
                cnt_nx   = 8'(chunk - 9'd1);
                state_nx = write ? WDATA : RDATA;
            end
            WDATA: if (u.wvalid && d.wready) begin
                cnt_nx = cnt - 8'd1;
                if (cnt == 8'd0) state_nx = DRESP;
            end
            DRESP: if (d.bvalid) begin
                state_nx = (rem != 9'd0) ? CMD : UBRESP;
            end
            UBRESP: if (u.bready) state_nx = IDLE;
            RDATA: if (d.rvalid && d.rlast) begin
                state_nx = (rem != 9'd0) ? CMD : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign u.arw_ready = !reset && state == IDLE;

    assign d.arw_valid = !reset && state == CMD;
    assign d.arw_addr  = addr;
    assign d.arw_len   = 8'(chunk - 9'd1);
    assign d.arw_write = write;
    assign d.arw_id    = id;

    assign d.wvalid = !reset && state == WDATA && u.wvalid;
    assign u.wready = !reset && state == WDATA && d.wready;
    assign d.wdata  = u.wdata;
    assign d.wstrb  = u.wstrb;
    assign d.wlast  = cnt == 8'd0;

    // Only one command is ever outstanding, so responses are always taken.
    assign d.bready = 1'b1;
    assign u.bvalid = !reset && state == UBRESP;
    assign u.bid    = id;

    assign u.rvalid = !reset && state == RDATA && d.rvalid;
    assign u.rdata  = d.rdata;
    assign u.rid    = id;
    assign u.rlast  = u.rvalid && d.rlast && rem == 9'd0;

    assign unused_ok = ^{u.wlast, d.bid, d.rid};
endmodule

// File: tb/tb_ddr_burst_splitter.sv
// Randomised bench for ddr_burst_splitter with a behavioural DDR
// controller responder and a chunking reference model.
module tb_ddr_burst_splitter;
    typedef struct packed {
        logic [26:0] addr;
        logic [7:0]  len;
        logic        write;
        logic [1:0]  id;
    } cmd_t;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } wbeat_t;
    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  id;
    } rbeat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ddr_burst_splitter_if #(.AW(27)) u_bus ();
    ddr_burst_splitter_if #(.AW(27)) d_bus ();

    ddr_burst_splitter #(
        .ROW_BITS(13), .COL_BITS(11), .MAX_BEATS(64)
    ) dut (
        .clk(clk), .reset(reset), .u(u_bus), .d(d_bus)
    );

    int checks = 0;
    int failures = 0;

    cmd_t        dcmd_q[$];
    wbeat_t      dw_q[$];
    rbeat_t      ur_q[$];
    logic [1:0]  ub_q[$];
    wbeat_t      wsent[$];
    int          viol;
    bit          tmo;
    int          stall_cnt, stall_bad;

    function automatic logic [31:0] rd_word(input logic [26:0] a);
        return ({5'd0, a} * 32'h9E3779B1) ^ 32'h0F0F_5A5A;
    endfunction

    // Beats in one controller command: stop at row end and at 64 beats.
    function automatic int model_chunk(input logic [26:0] a, input int rem);
        int in_row, c;
        in_row = 1024 - int'((a % 27'd4096) / 27'd4);
        c = rem;
        if (in_row < c) c = in_row;
        if (c > 64) c = 64;
        return c;
    endfunction

    // Behavioural DDR controller: one command at a time, random stalls.
    bit          busy, wr_mode, pend;
    int          wleft, rleft, bdelay;
    logic [26:0] raddr;
    cmd_t        pcmd;
    initial begin
        busy = 0; wr_mode = 0; pend = 0;
        wleft = 0; rleft = 0; bdelay = 0; raddr = '0; pcmd = '0;
        d_bus.arw_ready = 0; d_bus.wready = 0; d_bus.bvalid = 0;
        d_bus.bid = 0; d_bus.rvalid = 0; d_bus.rlast = 0;
        d_bus.rdata = 0; d_bus.rid = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 0; pend = 0; wleft = 0; rleft = 0;
                d_bus.arw_ready = 0; d_bus.wready = 0;
                d_bus.bvalid = 0; d_bus.rvalid = 0; d_bus.rlast = 0;
            end else begin
                d_bus.arw_ready = !busy && ($urandom_range(0, 2) != 0);
                d_bus.wready = $urandom_range(0, 3) != 0;
                d_bus.bid = 2'($urandom);
                if (busy && wr_mode && wleft == 0 && bdelay > 0) begin
                    bdelay--;
                    d_bus.bvalid = 0;
                end else begin
                    d_bus.bvalid = busy && wr_mode && wleft == 0;
                end
                d_bus.rvalid = busy && !wr_mode && ($urandom_range(0, 3) != 0);
                d_bus.rlast = busy && !wr_mode && rleft == 1;
                d_bus.rdata = rd_word(raddr);
                d_bus.rid = 2'($urandom);
            end
            #4;
            if (!reset) begin
                if (d_bus.arw_valid) begin
                    if (busy) viol++;
                    if (pend && pcmd !== {d_bus.arw_addr, d_bus.arw_len,
                                          d_bus.arw_write, d_bus.arw_id})
                        viol++;
                    pcmd = {d_bus.arw_addr, d_bus.arw_len,
                            d_bus.arw_write, d_bus.arw_id};
                    pend = !d_bus.arw_ready;
                    if (d_bus.arw_ready) begin
                        dcmd_q.push_back(pcmd);
                        busy = 1;
                        wr_mode = pcmd.write;
                        wleft = pcmd.write ? int'(pcmd.len) + 1 : 0;
                        rleft = pcmd.write ? 0 : int'(pcmd.len) + 1;
                        raddr = pcmd.addr;
                        bdelay = $urandom_range(0, 3);
                    end
                end else if (pend) begin
                    viol++;
                    pend = 0;
                end
                if (d_bus.wvalid && d_bus.wready) begin
                    if (!busy || !wr_mode || wleft == 0) viol++;
                    else begin
                        dw_q.push_back({d_bus.wdata, d_bus.wstrb, d_bus.wlast});
                        wleft--;
                    end
                end
                if (d_bus.bvalid && d_bus.bready) busy = 0;
                if (d_bus.rvalid) begin
                    rleft--;
                    raddr = raddr + 27'd4;
                    if (rleft == 0) busy = 0;
                end
            end else begin
                pend = 0;
            end
        end
    end

    // Upstream monitor: every u_rvalid beat must be taken.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                if (u_bus.rvalid)
                    ur_q.push_back({u_bus.rdata, u_bus.rlast, u_bus.rid});
                else if (u_bus.rlast)
                    viol++;
                if (u_bus.bvalid && u_bus.bready)
                    ub_q.push_back(u_bus.bid);
            end
        end
    end

    task automatic do_burst(input logic [26:0] a, input int len,
                            input bit wr, input logic [1:0] id,
                            input int bstall);
        int nb, sent, cyc, bcyc;
        bit acc, done;
        nb = len + 1; sent = 0; cyc = 0; bcyc = 0; acc = 0; done = 0;
        tmo = 0; stall_cnt = 0; stall_bad = 0; viol = 0;
        dcmd_q.delete(); dw_q.delete(); ur_q.delete(); ub_q.delete();
        wsent.delete();
        for (int i = 0; i < nb; i++)
            wsent.push_back({$urandom, 4'($urandom), 1'b0});
        while (!done) begin
            @(negedge clk);
            u_bus.arw_valid = !acc;
            u_bus.arw_addr = a;
            u_bus.arw_len = 8'(len);
            u_bus.arw_write = wr;
            u_bus.arw_id = id;
            u_bus.wvalid = wr && sent < nb && ($urandom_range(0, 3) != 0);
            if (sent < nb) begin
                u_bus.wdata = wsent[sent].data;
                u_bus.wstrb = wsent[sent].strb;
            end
            u_bus.wlast = (sent == nb - 1);
            if (u_bus.bvalid && bcyc < bstall) u_bus.bready = 0;
            else u_bus.bready = (bstall > 0) || ($urandom_range(0, 1) != 0);
            #4;
            if (u_bus.bvalid && bcyc < bstall) begin
                stall_cnt++;
                if (u_bus.arw_ready) stall_bad++;
            end
            if (u_bus.bvalid) bcyc++;
            if (u_bus.arw_valid && u_bus.arw_ready) acc = 1;
            if (u_bus.wvalid && u_bus.wready) sent++;
            if (wr && u_bus.bvalid && u_bus.bready) done = 1;
            if (!wr && u_bus.rvalid && u_bus.rlast) done = 1;
            cyc++;
            if (cyc > 3000) begin
                tmo = 1;
                done = 1;
            end
        end
        @(negedge clk);
        u_bus.arw_valid = 0;
        u_bus.wvalid = 0;
        u_bus.bready = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({u_bus.arw_ready, u_bus.bvalid, u_bus.rvalid, u_bus.rlast} !== 4'b0) begin
            failures++;
            $display("FAIL reset_u_outputs: got %b want 0000",
                     {u_bus.arw_ready, u_bus.bvalid, u_bus.rvalid, u_bus.rlast});
        end
        checks++;
        if ({d_bus.arw_valid, d_bus.wvalid, d_bus.bready} !== 3'b001) begin
            failures++;
            $display("FAIL reset_d_outputs: got %b want 001",
                     {d_bus.arw_valid, d_bus.wvalid, d_bus.bready});
        end
        reset = 0;
        @(negedge clk);
        #1;
        checks++;
        if ({u_bus.arw_ready, d_bus.arw_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_release_idle: got %b want 10",
                     {u_bus.arw_ready, d_bus.arw_valid});
        end
    endtask

    task automatic test_single_write;
        logic [3:0] lb;
        int bad;
        do_burst(27'h040, 3, 1'b1, 2'd1, 0);
        lb = '0; bad = 0;
        for (int i = 0; i < dw_q.size() && i < 4; i++) begin
            lb[i] = dw_q[i].last;
            if (dw_q[i].data !== wsent[i].data || dw_q[i].strb !== wsent[i].strb)
                bad++;
        end
        checks++;
        if (tmo || dcmd_q.size() != 1 || dw_q.size() != 4) begin
            failures++;
            $display("FAIL single_write_counts: tmo=%0d cmds=%0d beats=%0d want 0/1/4",
                     tmo, dcmd_q.size(), dw_q.size());
        end else begin
            checks++;
            if (dcmd_q[0] !== cmd_t'({27'h040, 8'd3, 1'b1, 2'd1})) begin
                failures++;
                $display("FAIL single_write_cmd: got %h want %h", dcmd_q[0],
                         cmd_t'({27'h040, 8'd3, 1'b1, 2'd1}));
            end
            checks++;
            if (lb !== 4'b1000 || bad != 0) begin
                failures++;
                $display("FAIL single_write_beats: wlast=%b want 1000 bad=%0d", lb, bad);
            end
        end
        checks++;
        if (ub_q.size() != 1 || ub_q[0] !== 2'd1) begin
            failures++;
            $display("FAIL single_write_bresp: count=%0d want 1 id 1", ub_q.size());
        end
    endtask

    task automatic test_row_cross_write;
        logic [3:0] lb;
        do_burst(27'h0FF8, 3, 1'b1, 2'd2, 0);
        lb = '0;
        for (int i = 0; i < dw_q.size() && i < 4; i++) lb[i] = dw_q[i].last;
        checks++;
        if (tmo || dcmd_q.size() != 2) begin
            failures++;
            $display("FAIL row_cross_cmds: tmo=%0d cmds=%0d want 0/2", tmo, dcmd_q.size());
        end else begin
            checks++;
            if (dcmd_q[0] !== cmd_t'({27'h0FF8, 8'd1, 1'b1, 2'd2}) ||
                dcmd_q[1] !== cmd_t'({27'h1000, 8'd1, 1'b1, 2'd2})) begin
                failures++;
                $display("FAIL row_cross_split: got %h %h want 0ff8/1 1000/1",
                         dcmd_q[0], dcmd_q[1]);
            end
        end
        checks++;
        if (dw_q.size() != 4 || lb !== 4'b1010) begin
            failures++;
            $display("FAIL row_cross_wlast: beats=%0d wlast=%b want 4 1010", dw_q.size(), lb);
        end
        checks++;
        if (ub_q.size() != 1 || ub_q[0] !== 2'd2 || viol != 0) begin
            failures++;
            $display("FAIL row_cross_bresp: count=%0d viol=%0d want 1 0", ub_q.size(), viol);
        end
    endtask

    task automatic test_long_read;
        int bad, nl;
        do_burst(27'h0, 255, 1'b0, 2'd3, 0);
        bad = 0;
        for (int k = 0; k < 4 && k < dcmd_q.size(); k++)
            if (dcmd_q[k] !== cmd_t'({27'(k * 256), 8'd63, 1'b0, 2'd3})) bad++;
        checks++;
        if (tmo || dcmd_q.size() != 4 || bad != 0) begin
            failures++;
            $display("FAIL long_read_cmds: tmo=%0d cmds=%0d bad=%0d want 0/4/0",
                     tmo, dcmd_q.size(), bad);
        end
        bad = 0; nl = 0;
        foreach (ur_q[i]) begin
            if (ur_q[i].last) nl++;
            if (ur_q[i].data !== rd_word(27'(i * 4)) || ur_q[i].id !== 2'd3) bad++;
        end
        checks++;
        if (ur_q.size() != 256 || nl != 1 || bad != 0 || !ur_q[ur_q.size() - 1].last) begin
            failures++;
            $display("FAIL long_read_beats: beats=%0d rlasts=%0d bad=%0d want 256/1/0",
                     ur_q.size(), nl, bad);
        end
    endtask

    task automatic test_read_row_end;
        do_burst(27'h0FFC, 0, 1'b0, 2'd0, 0);
        checks++;
        if (tmo || dcmd_q.size() != 1 ||
            dcmd_q[0] !== cmd_t'({27'h0FFC, 8'd0, 1'b0, 2'd0})) begin
            failures++;
            $display("FAIL row_end_cmd: tmo=%0d cmds=%0d want one 0ffc/0", tmo, dcmd_q.size());
        end
        checks++;
        if (ur_q.size() != 1 || ur_q[0] !== rbeat_t'({rd_word(27'h0FFC), 1'b1, 2'd0})) begin
            failures++;
            $display("FAIL row_end_beat: beats=%0d want 1 with rlast", ur_q.size());
        end
    endtask

    task automatic test_bready_stall;
        do_burst(27'h2000, 7, 1'b1, 2'd1, 10);
        checks++;
        if (tmo || stall_cnt != 10 || stall_bad != 0) begin
            failures++;
            $display("FAIL bready_stall: tmo=%0d held=%0d arw_ready_seen=%0d want 0/10/0",
                     tmo, stall_cnt, stall_bad);
        end
        checks++;
        if (ub_q.size() != 1 || ub_q[0] !== 2'd1) begin
            failures++;
            $display("FAIL bready_stall_resp: count=%0d want 1", ub_q.size());
        end
    endtask

    task automatic test_top_wrap;
        int bad;
        do_burst(27'h7FF_FFF8, 3, 1'b0, 2'd2, 0);
        checks++;
        if (tmo || dcmd_q.size() != 2) begin
            failures++;
            $display("FAIL top_wrap_cmds: tmo=%0d cmds=%0d want 0/2", tmo, dcmd_q.size());
        end else begin
            checks++;
            if (dcmd_q[1] !== cmd_t'({27'h0, 8'd1, 1'b0, 2'd2})) begin
                failures++;
                $display("FAIL top_wrap_addr: got %h want addr 0 len 1", dcmd_q[1]);
            end
        end
        bad = 0;
        foreach (ur_q[i])
            if (ur_q[i].data !== rd_word(27'h7FF_FFF8 + 27'(4 * i))) bad++;
        checks++;
        if (ur_q.size() != 4 || bad != 0) begin
            failures++;
            $display("FAIL top_wrap_data: beats=%0d bad=%0d want 4/0", ur_q.size(), bad);
        end
    endtask

    task automatic test_reset_mid;
        int cyc, sent, seen;
        bit acc;
        cyc = 0; sent = 0; seen = 0; acc = 0;
        dcmd_q.delete();
        while (sent < 1 && cyc < 2000) begin
            @(negedge clk);
            u_bus.arw_valid = !acc;
            u_bus.arw_addr = 27'h0FF8;
            u_bus.arw_len = 8'd3;
            u_bus.arw_write = 1'b1;
            u_bus.arw_id = 2'd1;
            u_bus.wvalid = acc && dcmd_q.size() > 0;
            u_bus.wdata = $urandom;
            u_bus.wstrb = 4'hF;
            #4;
            if (u_bus.arw_valid && u_bus.arw_ready) acc = 1;
            if (u_bus.wvalid && u_bus.wready) sent++;
            cyc++;
        end
        checks++;
        if (sent != 1) begin
            failures++;
            $display("FAIL reset_mid_setup: beats=%0d want 1 within budget", sent);
        end
        @(negedge clk);
        u_bus.arw_valid = 0;
        u_bus.wvalid = 0;
        u_bus.bready = 1;
        reset = 1;
        @(negedge clk);
        #1;
        checks++;
        if ({u_bus.arw_ready, d_bus.arw_valid, d_bus.wvalid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_hold: got %b want 000",
                     {u_bus.arw_ready, d_bus.arw_valid, d_bus.wvalid});
        end
        reset = 0;
        @(negedge clk);
        #1;
        checks++;
        if ({u_bus.arw_ready, d_bus.arw_valid, u_bus.bvalid} !== 3'b100) begin
            failures++;
            $display("FAIL reset_mid_idle: got %b want 100",
                     {u_bus.arw_ready, d_bus.arw_valid, u_bus.bvalid});
        end
        repeat (20) begin
            @(negedge clk);
            #1;
            if (u_bus.bvalid || d_bus.arw_valid || u_bus.rvalid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid_quiet: activity cycles=%0d want 0", seen);
        end
        u_bus.bready = 0;
    endtask

    task automatic test_random;
        cmd_t        exp_q[$];
        bit          lastm[$];
        logic [26:0] a, ea;
        logic [11:0] off;
        logic [1:0]  id;
        int          len, rem, c, bad;
        bit          wr;
        for (int n = 0; n < 30; n++) begin
            a = 27'($urandom) & ~27'h3;
            if ($urandom_range(0, 1) != 0) begin
                off = 12'(4096 - 4 * int'($urandom_range(1, 70)));
                a = {a[26:12], off};
            end
            len = $urandom_range(0, 255);
            wr = 1'($urandom);
            id = 2'($urandom);
            do_burst(a, len, wr, id, 0);
            exp_q.delete();
            lastm.delete();
            ea = a;
            rem = len + 1;
            while (rem > 0) begin
                c = model_chunk(ea, rem);
                exp_q.push_back({ea, 8'(c - 1), wr, id});
                for (int j = 0; j < c; j++) lastm.push_back(j == c - 1);
                ea = ea + 27'(4 * c);
                rem -= c;
            end
            bad = 0;
            foreach (exp_q[k])
                if (k >= dcmd_q.size() || dcmd_q[k] !== exp_q[k]) bad++;
            checks++;
            if (tmo || viol != 0 || bad != 0 || dcmd_q.size() != exp_q.size()) begin
                failures++;
                $display("FAIL rand_cmds[%0d]: a=%h len=%0d tmo=%0d viol=%0d cmds=%0d want %0d bad=%0d",
                         n, a, len, tmo, viol, dcmd_q.size(), exp_q.size(), bad);
            end
            bad = 0;
            if (wr) begin
                foreach (wsent[i])
                    if (i >= dw_q.size() ||
                        dw_q[i] !== wbeat_t'({wsent[i].data, wsent[i].strb, lastm[i]}))
                        bad++;
                checks++;
                if (bad != 0 || dw_q.size() != len + 1 || ur_q.size() != 0 ||
                    ub_q.size() != 1 || ub_q[0] !== id) begin
                    failures++;
                    $display("FAIL rand_write[%0d]: beats=%0d want %0d bad=%0d bresp=%0d want 1",
                             n, dw_q.size(), len + 1, bad, ub_q.size());
                end
            end else begin
                for (int i = 0; i <= len; i++)
                    if (i >= ur_q.size() ||
                        ur_q[i] !== rbeat_t'({rd_word(a + 27'(4 * i)), i == len, id}))
                        bad++;
                checks++;
                if (bad != 0 || ur_q.size() != len + 1 || ub_q.size() != 0) begin
                    failures++;
                    $display("FAIL rand_read[%0d]: beats=%0d want %0d bad=%0d bresp=%0d want 0",
                             n, ur_q.size(), len + 1, bad, ub_q.size());
                end
            end
        end
    endtask

    initial begin
        u_bus.arw_valid = 0; u_bus.arw_addr = '0; u_bus.arw_len = '0;
        u_bus.arw_write = 0; u_bus.arw_id = '0; u_bus.wvalid = 0;
        u_bus.wdata = '0; u_bus.wstrb = '0; u_bus.wlast = 0;
        u_bus.bready = 0;
        viol = 0;
        test_reset();
        test_single_write();
        test_row_cross_write();
        test_long_read();
        test_read_row_end();
        test_bready_stall();
        test_top_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
